// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM state encoding,
// the default reset PC and the jump-target alignment rule.
package mc_ctrl_pkg;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    typedef enum logic [3:0] {
        FETCH_REQ  = 4'd0,
        FETCH_WAIT = 4'd1,
        DECODE     = 4'd2,
        EXEC       = 4'd3,
        MEM_REQ    = 4'd4,
        MEM_WAIT   = 4'd5,
        WB         = 4'd6,
        HALT       = 4'd7,
        TRAP       = 4'd8
    } state_t;

    // Only word-aligned jump targets are legal; bit0 is already dropped for jalr.
    function automatic logic jump_target_misaligned(input logic is_jump, input logic target_bit1);
        return is_jump & target_bit1;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running performance counter with enable; wraps silently at 2^WIDTH.
module perf_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle core controller: sequences fetch, decode, execute, memory and
// writeback, owns the PC and the cycle/instret counters.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int                XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     inst,
    input  logic            dec_is_load,
    input  logic            dec_mem_wen,
    input  logic            dec_reg_wen,
    input  logic            dec_is_jal,
    input  logic            dec_is_jalr,
    input  logic            dec_is_ebreak,
    input  logic            dec_inst_not_ipl,
    input  logic [XLEN-1:0] jump_target,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    input  logic            dmem_rsp_valid,
    output logic [XLEN-1:0] pc,
    output logic            rf_wen,
    output logic            halted,
    output logic            trap,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt
);

    state_t          state;
    logic            wb_fault;
    logic            is_mem_op;
    logic            target_fault;
    logic [XLEN-1:0] next_pc;

    assign is_mem_op      = dec_is_load | dec_mem_wen;
    assign target_fault   = jump_target_misaligned(dec_is_jal | dec_is_jalr, jump_target[1]);
    assign imem_req_valid = (state == FETCH_REQ);
    assign dmem_req_valid = (state == MEM_REQ);
    assign imem_addr      = pc;

    always_comb begin
        next_pc = pc + XLEN'(4);
        if (dec_is_jal) begin
            next_pc = jump_target;
        end else if (dec_is_jalr) begin
            next_pc = {jump_target[XLEN-1:1], 1'b0};
        end
    end

    // The writeback decision (fault, rf_wen) is taken on entry to WB so that
    // rf_wen leaves a flop and is high for the WB cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_REQ;
            pc       <= RESET_PC;
            inst     <= '0;
            rf_wen   <= 1'b0;
            halted   <= 1'b0;
            trap     <= 1'b0;
            wb_fault <= 1'b0;
        end else begin
            rf_wen <= 1'b0;
            unique case (state)
                FETCH_REQ: begin
                    if (imem_req_ready) begin
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst  <= imem_rsp_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_is_ebreak) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (dec_inst_not_ipl) begin
                        state <= TRAP;
                        trap  <= 1'b1;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_mem_op) begin
                        state <= MEM_REQ;
                    end else begin
                        state    <= WB;
                        wb_fault <= target_fault;
                        rf_wen   <= dec_reg_wen & ~target_fault;
                    end
                end
                MEM_REQ: begin
                    if (dmem_req_ready) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_rsp_valid) begin
                        state    <= WB;
                        wb_fault <= target_fault;
                        rf_wen   <= dec_reg_wen & ~target_fault;
                    end
                end
                WB: begin
                    if (wb_fault) begin
                        state <= TRAP;
                        trap  <= 1'b1;
                    end else begin
                        pc    <= next_pc;
                        state <= FETCH_REQ;
                    end
                end
                HALT: state <= HALT;
                TRAP: state <= TRAP;
                default: begin
                    state <= TRAP;
                    trap  <= 1'b1;
                end
            endcase
        end
    end

    perf_counter #(.WIDTH(XLEN)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    ((state != HALT) && (state != TRAP)),
        .count (cycle_cnt)
    );

    perf_counter #(.WIDTH(XLEN)) u_instret_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    ((state == WB) && !wb_fault),
        .count (instret_cnt)
    );

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed vector table, hand-written corner
// sequences and randomized instructions against a behavioural model.
module tb_mc_ctrl;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst;
    logic        dec_is_load, dec_mem_wen, dec_reg_wen, dec_is_jal, dec_is_jalr;
    logic        dec_is_ebreak, dec_inst_not_ipl;
    logic [63:0] jump_target;
    logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
    logic [63:0] pc;
    logic        rf_wen, halted, trap;
    logic [63:0] cycle_cnt, instret_cnt;

    int n_compared = 0;
    int n_failed   = 0;

    typedef struct {
        logic [31:0] word;
        logic        is_load;
        logic        mem_wen;
        logic        reg_wen;
        logic        jal;
        logic        jalr;
        logic        ebreak;
        logic        not_ipl;
        logic [63:0] target;
        int          req_w;
        int          rsp_w;
        int          dreq_w;
        int          drsp_w;
    } instr_t;

    typedef struct {
        instr_t      ins;
        logic [63:0] exp_pc;
        int          exp_rf;
        int          exp_kind;
        int          exp_cycles;
        logic [63:0] exp_instret;
        int          exp_dv;
    } vec_t;

    vec_t tbl[14];

    mc_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_addr        (imem_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .inst             (inst),
        .dec_is_load      (dec_is_load),
        .dec_mem_wen      (dec_mem_wen),
        .dec_reg_wen      (dec_reg_wen),
        .dec_is_jal       (dec_is_jal),
        .dec_is_jalr      (dec_is_jalr),
        .dec_is_ebreak    (dec_is_ebreak),
        .dec_inst_not_ipl (dec_inst_not_ipl),
        .jump_target      (jump_target),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_rsp_valid   (dmem_rsp_valid),
        .pc               (pc),
        .rf_wen           (rf_wen),
        .halted           (halted),
        .trap             (trap),
        .cycle_cnt        (cycle_cnt),
        .instret_cnt      (instret_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // flags = {is_load, mem_wen, reg_wen, jal, jalr, ebreak, not_ipl}
    function automatic instr_t mk_ins(input logic [31:0] w, input logic [6:0] flags, input logic [63:0] t,
                                      input int rq, input int rs, input int dq, input int ds);
        instr_t r;
        r.word    = w;
        r.is_load = flags[6];
        r.mem_wen = flags[5];
        r.reg_wen = flags[4];
        r.jal     = flags[3];
        r.jalr    = flags[2];
        r.ebreak  = flags[1];
        r.not_ipl = flags[0];
        r.target  = t;
        r.req_w   = rq;
        r.rsp_w   = rs;
        r.dreq_w  = dq;
        r.drsp_w  = ds;
        return r;
    endfunction

    // kind: 0 = retires and fetches next, 1 = halt, 2 = trap
    function automatic void ref_model(input instr_t ins, input logic [63:0] cur_pc, output logic [63:0] nxt_pc,
                                      output int kind, output int rf, output int cycles,
                                      output int retired, output int dv);
        logic [63:0] t;
        logic        mem;
        nxt_pc  = cur_pc;
        rf      = 0;
        retired = 0;
        dv      = 0;
        if (ins.ebreak || ins.not_ipl) begin
            kind   = ins.ebreak ? 1 : 2;
            cycles = 3 + ins.req_w + ins.rsp_w;
        end else begin
            mem    = ins.is_load || ins.mem_wen;
            cycles = 5 + ins.req_w + ins.rsp_w + (mem ? 2 + ins.dreq_w + ins.drsp_w : 0);
            dv     = mem ? 1 + ins.dreq_w : 0;
            t      = ins.jalr ? ins.target - (ins.target % 2) : ins.target;
            if ((ins.jal || ins.jalr) && ((t / 2) % 2 == 1)) begin
                kind = 2;
            end else begin
                kind    = 0;
                nxt_pc  = (ins.jal || ins.jalr) ? t : cur_pc + 64'd4;
                rf      = ins.reg_wen ? 1 : 0;
                retired = 1;
            end
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        dec_is_load = 1'b0; dec_mem_wen = 1'b0; dec_reg_wen = 1'b0; dec_is_jal = 1'b0;
        dec_is_jalr = 1'b0; dec_is_ebreak = 1'b0; dec_inst_not_ipl = 1'b0; jump_target = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered at a negedge with the DUT in FETCH_REQ; acts as both memories.
    task automatic apply_stimulus(input instr_t v, input logic [63:0] fetch_pc, input string tag,
                                  output int cycles, output int rf_pulses, output int dv_cycles,
                                  output int end_kind, output int both_valid);
        int phase = 0;
        int cnt   = 0;
        int k     = 0;
        rf_pulses = 0; dv_cycles = 0; both_valid = 0; end_kind = -1;
        dec_is_load = v.is_load; dec_mem_wen = v.mem_wen; dec_reg_wen = v.reg_wen;
        dec_is_jal = v.jal; dec_is_jalr = v.jalr; dec_is_ebreak = v.ebreak;
        dec_inst_not_ipl = v.not_ipl; jump_target = v.target; imem_rsp_data = v.word;
        while (k < 80) begin
            if (halted) begin end_kind = 1; break; end
            if (trap)   begin end_kind = 2; break; end
            if (imem_req_valid && phase >= 2) begin end_kind = 0; break; end
            if (imem_req_valid && dmem_req_valid) both_valid++;
            if (rf_wen) rf_pulses++;
            if (dmem_req_valid) dv_cycles++;
            imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
            dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
            case (phase)
                0: if (imem_req_valid) begin
                       check_output({tag, ".imem_addr"}, imem_addr, fetch_pc);
                       if (cnt >= v.req_w) begin imem_req_ready = 1'b1; phase = 1; cnt = 0; end
                       else cnt++;
                   end
                1: if (cnt >= v.rsp_w) begin imem_rsp_valid = 1'b1; phase = 2; cnt = 0; end
                   else cnt++;
                2: if (dmem_req_valid) begin
                       if (cnt >= v.dreq_w) begin dmem_req_ready = 1'b1; phase = 3; cnt = 0; end
                       else cnt++;
                   end
                3: if (cnt >= v.drsp_w) begin dmem_rsp_valid = 1'b1; phase = 4; cnt = 0; end
                   else cnt++;
                default: ;
            endcase
            @(negedge clk);
            k++;
        end
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        cycles = k;
    endtask

    task automatic run_and_check(input instr_t ins, input logic [63:0] fetch_pc, input logic [63:0] exp_pc,
                                 input int exp_rf, input int exp_kind, input int exp_cycles,
                                 input logic [63:0] exp_cc, input logic [63:0] exp_ir, input int exp_dv,
                                 input string tag, output int got_kind);
        int cyc, rfp, dvc, bv;
        apply_stimulus(ins, fetch_pc, tag, cyc, rfp, dvc, got_kind, bv);
        check_output({tag, ".end_kind"}, 64'(got_kind), 64'(exp_kind));
        check_output({tag, ".latency"}, 64'(cyc), 64'(exp_cycles));
        check_output({tag, ".rf_wen_pulses"}, 64'(rfp), 64'(exp_rf));
        check_output({tag, ".dmem_valid_cycles"}, 64'(dvc), 64'(exp_dv));
        check_output({tag, ".both_req_valid"}, 64'(bv), 64'd0);
        check_output({tag, ".pc"}, pc, exp_pc);
        check_output({tag, ".instret"}, instret_cnt, exp_ir);
        check_output({tag, ".cycle_cnt"}, cycle_cnt, exp_cc);
        check_output({tag, ".inst"}, 64'(inst), 64'(ins.word));
        check_output({tag, ".halted"}, 64'(halted), 64'(exp_kind == 1));
        check_output({tag, ".trap"}, 64'(trap), 64'(exp_kind == 2));
    endtask

    initial begin
        int          kind;
        int          got;
        int          rf, cyc, ret, dv;
        int          imem_seen;
        logic [63:0] m_pc, m_cc, m_ir, nxt, frozen_cc;
        instr_t      ins;

        tbl[0]  = '{mk_ins(32'h00100093, 7'b0010000, 64'h0, 0, 0, 0, 0), 64'h8000_0004, 1, 0, 5, 64'd1, 0};
        tbl[1]  = '{mk_ins(32'h0000a103, 7'b1010000, 64'h0, 0, 0, 3, 0), 64'h8000_0004, 1, 0, 10, 64'd1, 4};
        tbl[2]  = '{mk_ins(32'h0020a023, 7'b0100000, 64'h0, 0, 0, 0, 1), 64'h8000_0004, 0, 0, 8, 64'd1, 1};
        tbl[3]  = '{mk_ins(32'h000080e7, 7'b0010100, 64'h8000_0101, 0, 0, 0, 0), 64'h8000_0100, 1, 0, 5, 64'd1, 0};
        tbl[4]  = '{mk_ins(32'h000080e7, 7'b0010100, 64'h8000_0102, 0, 0, 0, 0), 64'h8000_0000, 0, 2, 5, 64'd0, 0};
        tbl[5]  = '{mk_ins(32'h001000ef, 7'b0011000, 64'h8000_1000, 0, 0, 0, 0), 64'h8000_1000, 1, 0, 5, 64'd1, 0};
        tbl[6]  = '{mk_ins(32'h001000ef, 7'b0011000, 64'h8000_0006, 0, 0, 0, 0), 64'h8000_0000, 0, 2, 5, 64'd0, 0};
        tbl[7]  = '{mk_ins(32'h00100073, 7'b0000010, 64'h0, 0, 0, 0, 0), 64'h8000_0000, 0, 1, 3, 64'd0, 0};
        tbl[8]  = '{mk_ins(32'hffffffff, 7'b0000001, 64'h0, 0, 0, 0, 0), 64'h8000_0000, 0, 2, 3, 64'd0, 0};
        tbl[9]  = '{mk_ins(32'h00000000, 7'b0000000, 64'h0, 0, 0, 0, 0), 64'h8000_0004, 0, 0, 5, 64'd1, 0};
        tbl[10] = '{mk_ins(32'h00100093, 7'b0010000, 64'h0, 2, 3, 0, 0), 64'h8000_0004, 1, 0, 10, 64'd1, 0};
        tbl[11] = '{mk_ins(32'h0000a103, 7'b1010000, 64'h0, 0, 0, 1, 2), 64'h8000_0004, 1, 0, 10, 64'd1, 2};
        tbl[12] = '{mk_ins(32'h000080e7, 7'b0010100, 64'h8000_0203, 0, 0, 0, 0), 64'h8000_0000, 0, 2, 5, 64'd0, 0};
        tbl[13] = '{mk_ins(32'h000080e7, 7'b0000100, 64'h8000_0105, 1, 1, 0, 0), 64'h8000_0104, 0, 0, 7, 64'd1, 0};

        do_reset();
        check_output("reset.pc", pc, RST_PC);
        check_output("reset.inst", 64'(inst), 64'd0);
        check_output("reset.cycle_cnt", cycle_cnt, 64'd0);
        check_output("reset.instret", instret_cnt, 64'd0);
        check_output("reset.rf_wen", 64'(rf_wen), 64'd0);
        check_output("reset.halted", 64'(halted), 64'd0);
        check_output("reset.trap", 64'(trap), 64'd0);
        check_output("reset.imem_req_valid", 64'(imem_req_valid), 64'd1);
        check_output("reset.dmem_req_valid", 64'(dmem_req_valid), 64'd0);

        for (int i = 0; i < 14; i++) begin
            do_reset();
            run_and_check(tbl[i].ins, RST_PC, tbl[i].exp_pc, tbl[i].exp_rf, tbl[i].exp_kind,
                          tbl[i].exp_cycles, 64'(tbl[i].exp_cycles), tbl[i].exp_instret,
                          tbl[i].exp_dv, $sformatf("vec%0d", i), got);
        end

        // ebreak: everything frozen while halted
        do_reset();
        run_and_check(tbl[7].ins, RST_PC, RST_PC, 0, 1, 3, 64'd3, 64'd0, 0, "halt", got);
        frozen_cc = 64'd3;
        imem_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid || dmem_req_valid) imem_seen++;
            @(negedge clk);
        end
        check_output("halt.mem_requests", 64'(imem_seen), 64'd0);
        check_output("halt.cycle_cnt_frozen", cycle_cnt, frozen_cc);
        check_output("halt.still_halted", 64'(halted), 64'd1);

        // pc wraps modulo 2^64
        do_reset();
        ins = mk_ins(32'h001000ef, 7'b0011000, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
        run_and_check(ins, RST_PC, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 5, 64'd5, 64'd1, 0, "wrap_jal", got);
        ins = mk_ins(32'h00100093, 7'b0010000, 64'h0, 0, 0, 0, 0);
        run_and_check(ins, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 0, 5, 64'd10, 64'd2, 0, "wrap_addi", got);

        // reset in FETCH_WAIT, stale response one cycle later
        do_reset();
        ins = mk_ins(32'h00100093, 7'b0010000, 64'h0, 0, 0, 0, 0);
        run_and_check(ins, RST_PC, 64'h8000_0004, 1, 0, 5, 64'd5, 64'd1, 0, "pre_rst", got);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check_output("rst_wait.pc", pc, RST_PC);
        check_output("rst_wait.inst", 64'(inst), 64'd0);
        check_output("rst_wait.imem_req_valid", 64'(imem_req_valid), 64'd1);
        check_output("rst_wait.imem_addr", imem_addr, RST_PC);
        check_output("rst_wait.instret", instret_cnt, 64'd0);
        ins = mk_ins(32'h00200113, 7'b0010000, 64'h0, 0, 0, 0, 0);
        run_and_check(ins, RST_PC, 64'h8000_0004, 1, 0, 5, 64'd6, 64'd1, 0, "post_rst", got);

        // randomized instruction stream against the behavioural model
        do_reset();
        m_pc = RST_PC; m_cc = 0; m_ir = 0;
        for (int n = 0; n < 150; n++) begin
            int r;
            r = $urandom_range(0, 99);
            ins = mk_ins($urandom, 7'b0, {$urandom, $urandom} & ~64'h3,
                         $urandom_range(0, 2), $urandom_range(0, 2),
                         $urandom_range(0, 2), $urandom_range(0, 2));
            if (r < 40) begin
                ins.reg_wen = 1'($urandom_range(0, 1));
            end else if (r < 55) begin
                ins.is_load = 1'b1; ins.reg_wen = 1'b1;
            end else if (r < 65) begin
                ins.mem_wen = 1'b1;
            end else if (r < 78) begin
                ins.jal = 1'b1; ins.reg_wen = 1'b1;
            end else if (r < 90) begin
                ins.jalr = 1'b1; ins.reg_wen = 1'b1;
                ins.target = ins.target | 64'($urandom_range(0, 1));
            end else if (r < 94) begin
                ins.jal = r[0]; ins.jalr = ~r[0]; ins.reg_wen = 1'b1;
                ins.target = ins.target | 64'h2;
            end else if (r < 97) begin
                ins.ebreak = 1'b1;
            end else begin
                ins.not_ipl = 1'b1;
            end
            ref_model(ins, m_pc, nxt, kind, rf, cyc, ret, dv);
            m_cc = m_cc + 64'(cyc);
            m_ir = m_ir + 64'(ret);
            run_and_check(ins, m_pc, nxt, rf, kind, cyc, m_cc, m_ir, dv, $sformatf("rnd%0d", n), got);
            m_pc = nxt;
            if (kind != 0 || got != 0) begin
                do_reset();
                m_pc = RST_PC; m_cc = 0; m_ir = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
